seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller. It is the successor to the fixed 8-digit hex display driver on the board I/O path.
- Adds: configurable digit count, per-digit decimal points, leading-zero blanking, a raw-segment mode, per-digit blink, PWM brightness, and tear-free frame-synchronous data update.
- Sits between the CPU's memory-mapped display register and the board's seg/sel pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_digit_fmt.sv | 43 ++++
 rtl/seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and helpers for the seg7_scan_ctrl block.
//               HEX_SEG  - active-high a..g patterns for nibbles 0..F
//               SEG_DP   - bit index of the decimal point in a segment byte
//               seg_polarity() - applies the pin polarity to a segment byte
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int SEG_DP = 7;

    // Bit0..6 = a..g, bit7 (dp) always clear here.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Converts an active-high pattern into the pin level.
    function automatic logic [7:0] seg_polarity(input logic [7:0] seg,
                                                input logic       active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_fmt.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_fmt
// Description : Combinational formatter for the digit currently scanned.
//               Produces the active-high 8-bit segment pattern.
// Ports       : i_nibble      hex value (hex mode)
//               i_raw         raw segment byte (raw mode)
//               i_dp          decimal point (hex mode)
//               i_mode        0 = hex, 1 = raw
//               i_lz_blank    digit is a leading zero to be suppressed
//               i_blink_blank digit is in the off half of its blink cycle
//               o_pattern     active-high pattern, bit0..6 = a..g, bit7 = dp
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_fmt
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic [7:0] i_raw,
    input  logic       i_dp,
    input  logic       i_mode,
    input  logic       i_lz_blank,
    input  logic       i_blink_blank,
    output logic [7:0] o_pattern
);

    always_comb begin
        o_pattern = 8'h00;
        if (i_blink_blank) begin
            o_pattern = 8'h00;
        end else if (i_mode) begin
            o_pattern = i_raw;
        end else begin
            // A suppressed leading zero still shows its decimal point.
            if (!i_lz_blank) begin
                o_pattern[6:0] = HEX_SEG[i_nibble][6:0];
            end
            o_pattern[SEG_DP] = i_dp;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Multiplexed 7-segment scan controller with frame-synchronous
//               data update, leading-zero blanking, raw mode, blink and PWM
//               brightness.
// Ports       : clk, rstn (async, active low)
//               disp_mode/i_data/i_raw/i_dp/i_blank_lz/i_blink - display data,
//                   captured on i_load and applied at the next frame start
//               i_bright - live brightness (all-ones = always on)
//               o_seg/o_sel - registered segment and digit-select pins
//               o_frame - one-cycle pulse at each frame start
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DIV_W          = 15,
    parameter int BRIGHT_W       = 3,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    disp_mode,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [8*NUM_DIGITS-1:0] i_raw,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_blank_lz,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    input  logic [BRIGHT_W-1:0]     i_bright,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_sel,
    output logic                    o_frame
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Shadowed fields packed as {mode, blank_lz, blink, dp, raw, data}.
    localparam int SH_W  = 2 + 14*NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS-1);
    localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(BLINK_FRAMES-1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

    logic [DIV_W-1:0]      pre_cnt_q,  pre_cnt_d;
    logic [IDX_W-1:0]      dig_idx_q,  dig_idx_d;
    logic [FRM_W-1:0]      frm_cnt_q,  frm_cnt_d;
    logic                  blink_ph_q, blink_ph_d;
    logic [SH_W-1:0]       pend_q,     pend_d;
    logic                  pend_v_q,   pend_v_d;
    logic [SH_W-1:0]       disp_q,     disp_d;
    logic [7:0]            seg_q,      seg_d;
    logic [NUM_DIGITS-1:0] sel_q,      sel_d;
    logic                  frame_q,    frame_d;

    logic                    slot_end;
    logic                    frame_wrap;
    logic                    lit;
    logic [SH_W-1:0]         in_vec;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [8*NUM_DIGITS-1:0] disp_raw;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blink;
    logic                    disp_lz;
    logic                    disp_mode_r;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic                    lz_run;
    logic [3:0]              cur_nib;
    logic [7:0]              cur_raw;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    cur_blink;
    logic [7:0]              pattern;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    assign in_vec      = {disp_mode, i_blank_lz, i_blink, i_dp, i_raw, i_data};
    assign disp_data   = disp_q[4*NUM_DIGITS-1:0];
    assign disp_raw    = disp_q[12*NUM_DIGITS-1:4*NUM_DIGITS];
    assign disp_dp     = disp_q[13*NUM_DIGITS-1:12*NUM_DIGITS];
    assign disp_blink  = disp_q[14*NUM_DIGITS-1:13*NUM_DIGITS];
    assign disp_lz     = disp_q[14*NUM_DIGITS];
    assign disp_mode_r = disp_q[14*NUM_DIGITS+1];

    assign slot_end   = &pre_cnt_q;
    assign frame_wrap = slot_end && (dig_idx_q == LAST_IDX);
    assign lit        = (pre_cnt_q[DIV_W-1 -: BRIGHT_W] <= i_bright);

    // lz_vec[k]: digit k and every digit above it hold nibble 0.
    always_comb begin
        lz_run = 1'b1;
        lz_vec = '0;
        for (int k = NUM_DIGITS-1; k >= 0; k--) begin
            lz_run    = lz_run & (disp_data[4*k +: 4] == 4'h0);
            lz_vec[k] = lz_run;
        end
        lz_vec[0] = 1'b0;
    end

    // Select the fields of the digit being scanned.
    always_comb begin
        cur_nib   = '0;
        cur_raw   = '0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        cur_blink = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_idx_q == IDX_W'(k)) begin
                cur_nib   = disp_data[4*k +: 4];
                cur_raw   = disp_raw[8*k +: 8];
                cur_dp    = disp_dp[k];
                cur_lz    = lz_vec[k];
                cur_blink = disp_blink[k];
            end
        end
    end

    seg7_digit_fmt u_fmt (
        .i_nibble      (cur_nib),
        .i_raw         (cur_raw),
        .i_dp          (cur_dp),
        .i_mode        (disp_mode_r),
        .i_lz_blank    (disp_lz & cur_lz),
        .i_blink_blank (cur_blink & blink_ph_q),
        .o_pattern     (pattern)
    );

    always_comb begin
        pre_cnt_d  = pre_cnt_q + DIV_W'(1);
        dig_idx_d  = dig_idx_q;
        frm_cnt_d  = frm_cnt_q;
        blink_ph_d = blink_ph_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        disp_d     = disp_q;

        if (slot_end) begin
            dig_idx_d = frame_wrap ? '0 : dig_idx_q + IDX_W'(1);
        end

        if (frame_wrap) begin
            if (frm_cnt_q == LAST_FRM) begin
                frm_cnt_d  = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                frm_cnt_d  = frm_cnt_q + FRM_W'(1);
            end
        end

        if (i_load) begin
            pend_d   = in_vec;
            pend_v_d = 1'b1;
        end

        // Display data only changes between frames so a digit row never tears.
        // A load landing on the wrap cycle itself goes straight through.
        if (frame_wrap) begin
            if (i_load) begin
                disp_d   = in_vec;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end

        sel_onehot = lit ? (NUM_DIGITS'(1) << dig_idx_q) : '0;
        seg_d      = seg_polarity(lit ? pattern : 8'h00, SEG_INV);
        sel_d      = sel_onehot ^ {NUM_DIGITS{SEL_INV}};
        frame_d    = frame_wrap;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt_q  <= '0;
            dig_idx_q  <= '0;
            frm_cnt_q  <= '0;
            blink_ph_q <= 1'b0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            disp_q     <= '0;
            seg_q      <= seg_polarity(8'h00, SEG_INV);
            sel_q      <= {NUM_DIGITS{SEL_INV}};
            frame_q    <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            dig_idx_q  <= dig_idx_d;
            frm_cnt_q  <= frm_cnt_d;
            blink_ph_q <= blink_ph_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            disp_q     <= disp_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            frame_q    <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign o_frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl. Instance A: 8 digits,
//               16-cycle slots, 2-frame blink. Instance B: 5 digits, raw mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic        rstn, disp_mode, i_load, i_blank_lz, o_frame;
    logic [31:0] i_data;
    logic [63:0] i_raw;
    logic [7:0]  i_dp, i_blink, o_seg, o_sel;
    logic [2:0]  i_bright;

    seg7_scan_ctrl #(.NUM_DIGITS(8), .DIV_W(4), .BRIGHT_W(3), .BLINK_FRAMES(2),
                     .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rstn(rstn), .disp_mode(disp_mode), .i_load(i_load),
        .i_data(i_data), .i_raw(i_raw), .i_dp(i_dp), .i_blank_lz(i_blank_lz),
        .i_blink(i_blink), .i_bright(i_bright),
        .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame)
    );

    // ---------------- instance B ----------------
    logic        b_rstn, b_mode, b_load, b_lz, b_frame;
    logic [19:0] b_data;
    logic [39:0] b_raw;
    logic [4:0]  b_dp, b_blink, b_sel;
    logic [2:0]  b_bright;
    logic [7:0]  b_seg;

    seg7_scan_ctrl #(.NUM_DIGITS(5), .DIV_W(4), .BRIGHT_W(3), .BLINK_FRAMES(1),
                     .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_dut_b (
        .clk(clk), .rstn(b_rstn), .disp_mode(b_mode), .i_load(b_load),
        .i_data(b_data), .i_raw(b_raw), .i_dp(b_dp), .i_blank_lz(b_lz),
        .i_blink(b_blink), .i_bright(b_bright),
        .o_seg(b_seg), .o_sel(b_sel), .o_frame(b_frame)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for A ----------------
    // Time is counted in scan steps since reset release; every load is logged
    // with its step. The data shown in frame f is the newest load made no
    // later than the last step of frame f-1.
    typedef struct {
        int          t;
        logic        mode;
        logic [31:0] data;
        logic [63:0] raw;
        logic [7:0]  dp;
        logic        lz;
        logic [7:0]  blink;
    } load_t;

    load_t loads[$];
    int    st;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st <= 0;
            loads.delete();
        end else begin
            if (i_load)
                loads.push_back('{t: st, mode: disp_mode, data: i_data, raw: i_raw,
                                  dp: i_dp, lz: i_blank_lz, blink: i_blink});
            st <= st + 1;
        end
    end

    function automatic void model(input int s, input logic [2:0] br,
                                  output logic [7:0] seg, output logic [7:0] sel,
                                  output logic frm);
        int         pre, k, f;
        load_t      d;
        logic [7:0] pat;
        pre = s % 16;
        k   = (s / 16) % 8;
        f   = s / 128;
        d.t = 0; d.mode = 0; d.data = 0; d.raw = 0; d.dp = 0; d.lz = 0; d.blink = 0;
        foreach (loads[i]) if (loads[i].t <= f*128 - 1) d = loads[i];
        if (d.blink[k] && ((f / 2) % 2 == 1)) begin
            pat = 8'h00;
        end else if (d.mode) begin
            pat = d.raw[8*k +: 8];
        end else begin
            pat = HEX_TAB[d.data[4*k +: 4]];
            if (d.lz && k > 0 && (d.data >> (4*k)) == 32'h0) pat = 8'h00;
            if (d.dp[k]) pat = pat | 8'h80;
        end
        frm = ((s % 128) == 127);
        if ((pre / 2) <= int'(br)) begin
            seg = ~pat;
            sel = ~(8'h01 << k);
        end else begin
            seg = 8'hFF;
            sel = 8'hFF;
        end
    endfunction

    logic       chk_en = 1'b0;
    logic [7:0] m_seg, m_sel;
    logic       m_frm;

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            if (st == 0) begin
                m_seg = 8'hFF; m_sel = 8'hFF; m_frm = 1'b0;
            end else begin
                model(st - 1, i_bright, m_seg, m_sel, m_frm);
            end
            check("model_seg",   {56'h0, o_seg}, {56'h0, m_seg});
            check("model_sel",   {56'h0, o_sel}, {56'h0, m_sel});
            check("model_frame", {63'h0, o_frame}, {63'h0, m_frm});
        end
    end

    // ---------------- helpers ----------------
    task automatic load_a(input logic mode, input logic [31:0] data, input logic [63:0] raw,
                          input logic [7:0] dp, input logic lz, input logic [7:0] blink);
        @(negedge clk);
        disp_mode = mode; i_data = data; i_raw = raw; i_dp = dp;
        i_blank_lz = lz; i_blink = blink; i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
    endtask

    // Returns at the sample point (posedge+2) where the frame pulse is high.
    task automatic wait_frame(input bit use_b);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (use_b ? b_frame : o_frame) return;
        end
        check(use_b ? "frame_timeout_b" : "frame_timeout_a", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] data;
        logic [63:0] raw;
        logic [7:0]  dp;
        logic        lz;
        logic [63:0] exp;   // expected pin byte of digit k at [8k +: 8]
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{mode: 0, data: 32'h1234ABCD, raw: 0, dp: 8'h00, lz: 0, exp: 64'hF9A4B0998883C6A1};
        vecs[1] = '{mode: 0, data: 32'h00000050, raw: 0, dp: 8'h00, lz: 1, exp: 64'hFFFFFFFFFFFF92C0};
        vecs[2] = '{mode: 0, data: 32'h00000050, raw: 0, dp: 8'h81, lz: 0, exp: 64'h40C0C0C0C0C09240};
        vecs[3] = '{mode: 1, data: 32'h12345678, raw: 64'h0102040810204080, dp: 8'hFF, lz: 1,
                    exp: 64'hFEFDFBF7EFDFBF7F};
        vecs[4] = '{mode: 0, data: 32'h00000000, raw: 0, dp: 8'h04, lz: 1, exp: 64'hFFFFFFFFFF7FFFC0};
        vecs[5] = '{mode: 0, data: 32'h000F0000, raw: 0, dp: 8'h00, lz: 1, exp: 64'hFFFFFF8EC0C0C0C0};

        rstn = 0; disp_mode = 0; i_load = 0; i_data = 0; i_raw = 0; i_dp = 0;
        i_blank_lz = 0; i_blink = 0; i_bright = 3'd7;
        b_rstn = 0; b_mode = 0; b_load = 0; b_data = 0; b_raw = 0; b_dp = 0;
        b_lz = 0; b_blink = 0; b_bright = 3'd7;
        chk_en = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_seg", {56'h0, o_seg}, 64'hFF);
        check("reset_sel", {56'h0, o_sel}, 64'hFF);
        rstn = 1;

        // Table: each vector is loaded, then every digit of the next frame is checked.
        for (int v = 0; v < 6; v++) begin
            load_a(vecs[v].mode, vecs[v].data, vecs[v].raw, vecs[v].dp, vecs[v].lz, 8'h00);
            wait_frame(0);
            repeat (8) @(posedge clk); #2;
            for (int k = 0; k < 8; k++) begin
                check($sformatf("vec%0d_seg%0d", v, k), {56'h0, o_seg}, {56'h0, vecs[v].exp[8*k +: 8]});
                check($sformatf("vec%0d_sel%0d", v, k), {56'h0, o_sel}, {56'h0, ~(8'h01 << k)});
                repeat (16) @(posedge clk); #2;
            end
        end

        // Mid-frame load stays hidden until the frame boundary.
        load_a(0, 32'h11111111, 0, 8'h00, 0, 8'h00);
        wait_frame(0);
        repeat (56) @(posedge clk);
        load_a(0, 32'h22222222, 0, 8'h00, 0, 8'h00);
        @(posedge clk); #2;
        check("tear_old_mid", {56'h0, o_seg}, 64'hF9);
        wait_frame(0);
        check("tear_old_last", {56'h0, o_seg}, 64'hF9);
        repeat (8) @(posedge clk); #2;
        check("tear_new_d0", {56'h0, o_seg}, 64'hA4);

        // Load on the wrap cycle itself is shown in the frame that follows at once.
        wait_frame(0);
        repeat (127) @(posedge clk);
        @(negedge clk);
        i_data = 32'h33333333; i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        @(posedge clk); #2;
        check("bypass_seg", {56'h0, o_seg}, 64'hB0);
        check("bypass_sel", {56'h0, o_sel}, 64'hFE);

        // Brightness 1: four lit cycles per 16-cycle slot.
        @(negedge clk); i_bright = 3'd1;
        wait_frame(0);
        begin
            int lit_cnt;
            lit_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                @(posedge clk); #2;
                if (o_sel != 8'hFF) lit_cnt++;
            end
            check("bright_lit_cycles", 64'(lit_cnt), 64'd4);
        end
        @(negedge clk); i_bright = 3'd7;

        // Pending data is discarded by a reset; scan restarts at digit 0.
        load_a(0, 32'h88888888, 0, 8'h00, 0, 8'h00);
        rstn = 0;
        @(negedge clk); rstn = 1;
        @(posedge clk); #2;
        check("rst_mid_seg", {56'h0, o_seg}, 64'hC0);
        check("rst_mid_sel", {56'h0, o_sel}, 64'hFE);

        // Blink on digit 0: frames 1 lit, 2-3 blank, 4 lit.
        load_a(0, 32'h00000001, 0, 8'h00, 0, 8'h01);
        wait_frame(0);
        repeat (8) @(posedge clk); #2;
        for (int f = 1; f <= 4; f++) begin
            check($sformatf("blink_f%0d", f), {56'h0, o_seg}, (f == 2 || f == 3) ? 64'hFF : 64'hF9);
            repeat (16) @(posedge clk); #2;
            check($sformatf("blink_d1_f%0d", f), {56'h0, o_seg}, 64'hC0);
            repeat (112) @(posedge clk); #2;
        end

        // Random traffic, checked every cycle against the model.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 150)) @(negedge clk);
            i_bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0)
                load_a(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 31),
                       {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)),
                       8'($urandom));
        end
        repeat (300) @(posedge clk);
        chk_en = 1'b0;

        // Instance B: 5 digits, raw mode, non-power-of-2 wrap.
        @(negedge clk);
        b_rstn = 1;
        b_mode = 1; b_raw = 40'h007F000000; b_dp = 5'h1F; b_lz = 1; b_load = 1;
        @(negedge clk);
        b_load = 0;
        wait_frame(1);
        repeat (8) @(posedge clk); #2;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("b_sel%0d", k), {59'h0, b_sel}, {59'h0, ~(5'b00001 << (k % 5))});
            check($sformatf("b_seg%0d", k), {56'h0, b_seg}, (k % 5 == 3) ? 64'h80 : 64'hFF);
            repeat (16) @(posedge clk); #2;
        end
        wait_frame(1);
        begin
            int gap;
            gap = 0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #2;
                gap++;
                if (b_frame) break;
            end
            check("b_frame_period", 64'(gap), 64'd80);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
